// File: rtl/button_conditioner.sv
// Synchronises and debounces active-low push buttons, producing clean levels and press/release pulses.
// Optional long-press setup-mode toggle on button 3, enabled by defining BTN_LONGPRESS_EN.
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20,
    parameter int LONG_CYCLES     = 100000000,
    parameter int LONG_CNT_W      = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic               setup_mode
);

    localparam int                  LONG_BTN = 3;
    localparam logic [DB_CNT_W-1:0] DB_LAST  = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0]  r_sync1;
    logic [NUM_BTN-1:0]  r_sync2;
    logic [NUM_BTN-1:0]  r_db;
    logic [NUM_BTN-1:0]  r_press;
    logic [NUM_BTN-1:0]  r_release;
    logic [DB_CNT_W-1:0] r_cnt     [NUM_BTN];
    logic [DB_CNT_W-1:0] w_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0]  w_db_nxt;

    // Idle level of the active-low pins is 1, so the synchroniser resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_db[i]) begin
                if (r_cnt[i] == DB_LAST) begin
                    w_db_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + DB_CNT_W'(1);
                end
            end
        end
    end

    // Pulses are registered alongside btn_db so they line up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db      <= '1;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_db      <= w_db_nxt;
            r_press   <= r_db & ~w_db_nxt;
            r_release <= ~r_db & w_db_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign btn_db        = r_db;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

`ifdef BTN_LONGPRESS_EN
    localparam logic [LONG_CNT_W-1:0] LONG_LAST = LONG_CNT_W'(LONG_CYCLES - 1);

    logic [LONG_CNT_W-1:0] r_lcnt;
    logic                  r_fired;
    logic                  r_setup;

    // One toggle per hold: r_fired blocks further counting until the button is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt  <= '0;
            r_fired <= 1'b0;
            r_setup <= 1'b0;
        end else if (r_db[LONG_BTN]) begin
            r_lcnt  <= '0;
            r_fired <= 1'b0;
        end else if (!r_fired) begin
            if (r_lcnt == LONG_LAST) begin
                r_setup <= ~r_setup;
                r_fired <= 1'b1;
                r_lcnt  <= '0;
            end else begin
                r_lcnt <= r_lcnt + LONG_CNT_W'(1);
            end
        end
    end

    assign setup_mode = r_setup;
`else
    logic [LONG_CNT_W-1:0] w_unused_long;

    assign w_unused_long = LONG_CNT_W'(LONG_CYCLES - 1);
    assign setup_mode    = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/long-press times.
// Expected outputs are queued per cycle and compared by a negedge monitor.
module tb_button_conditioner;

    localparam int NB  = 4;
    localparam int DBC = 4;
    localparam int LC  = 10;
`ifdef BTN_LONGPRESS_EN
    localparam logic LP_ON = 1'b1;
`else
    localparam logic LP_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_db;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic          setup_mode;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DBC),
        .DB_CNT_W       (3),
        .LONG_CYCLES    (LC),
        .LONG_CNT_W     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .setup_mode   (setup_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int       cyc;
        logic [3:0] db;
        logic [3:0] pp;
        logic [3:0] rp;
        logic       sm;
    } exp_t;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] db;
        logic [3:0] pp;
        logic [3:0] rp;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int c, input logic [3:0] db, input logic [3:0] pp,
                             input logic [3:0] rp, input logic sm);
        exp_t e;
        e.cyc = c; e.db = db; e.pp = pp; e.rp = rp; e.sm = sm;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare queued expectations on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_check got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("btn_db", btn_db, e.db);
                chk("press_pulse", press_pulse, e.pp);
                chk("release_pulse", release_pulse, e.rp);
                chk("setup_mode", {3'b000, setup_mode}, {3'b000, e.sm});
            end
        end
    end

    initial begin
        vec_t       tbl[10];
        logic [3:0] prev;
        int         k;

        tbl[0] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
        tbl[1] = '{4'b1110, 4'b1110, 4'b0001, 4'b0000};
        tbl[2] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001};
        tbl[3] = '{4'b1100, 4'b1100, 4'b0011, 4'b0000};
        tbl[4] = '{4'b1111, 4'b1111, 4'b0000, 4'b0011};
        tbl[5] = '{4'b0101, 4'b0101, 4'b1010, 4'b0000};
        tbl[6] = '{4'b1010, 4'b1010, 4'b0101, 4'b1010};
        tbl[7] = '{4'b1111, 4'b1111, 4'b0000, 4'b0101};
        tbl[8] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
        tbl[9] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};

        // Reset with all buttons held
        rst_n   = 1'b0;
        btn_raw = 4'b0000;
        step(3);
        chk("rst_btn_db", btn_db, 4'b1111);
        chk("rst_press", press_pulse, 4'b0000);
        chk("rst_release", release_pulse, 4'b0000);
        chk("rst_setup", {3'b000, setup_mode}, 4'b0000);
        rst_n = 1'b1;
        k = cyc;
        expect_at(k + 5, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 6, 4'b0000, 4'b1111, 4'b0000, 1'b0);
        expect_at(k + 7, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(9);

        // Table: clean presses/releases, simultaneous and mixed edges.
        // Each hold is short enough that button 3 never reaches a long press.
        prev = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            btn_raw = tbl[i].raw;
            k = cyc;
            expect_at(k + 5, prev, 4'b0000, 4'b0000, 1'b0);
            expect_at(k + 6, tbl[i].db, tbl[i].pp, tbl[i].rp, 1'b0);
            expect_at(k + 7, tbl[i].db, 4'b0000, 4'b0000, 1'b0);
            prev = tbl[i].db;
            step(9);
        end
        drain();

        // Bounce: low 3 cycles, high 1, low again
        k = cyc;
        btn_raw = 4'b1110;
        for (int c = 1; c <= 9; c++) begin
            expect_at(k + c, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        end
        expect_at(k + 10, 4'b1110, 4'b0001, 4'b0000, 1'b0);
        expect_at(k + 11, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 12, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        step(3);
        btn_raw = 4'b1111;
        step(1);
        btn_raw = 4'b1110;
        step(10);
        btn_raw = 4'b1111;
        k = cyc;
        expect_at(k + 5, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 6, 4'b1111, 4'b0000, 4'b0001, 1'b0);
        expect_at(k + 7, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        step(9);
        drain();

        // Long press on button 3: toggle on, release, toggle off
        k = cyc;
        btn_raw = 4'b0111;
        expect_at(k + 6,  4'b0111, 4'b1000, 4'b0000, 1'b0);
        expect_at(k + 15, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 16, 4'b0111, 4'b0000, 4'b0000, LP_ON);
        expect_at(k + 30, 4'b0111, 4'b0000, 4'b0000, LP_ON);
        step(30);
        btn_raw = 4'b1111;
        k = cyc;
        expect_at(k + 6, 4'b1111, 4'b0000, 4'b1000, LP_ON);
        step(10);
        btn_raw = 4'b0111;
        k = cyc;
        expect_at(k + 6,  4'b0111, 4'b1000, 4'b0000, LP_ON);
        expect_at(k + 15, 4'b0111, 4'b0000, 4'b0000, LP_ON);
        expect_at(k + 16, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 25, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        step(25);
        btn_raw = 4'b1111;
        k = cyc;
        expect_at(k + 6, 4'b1111, 4'b0000, 4'b1000, 1'b0);
        step(10);
        drain();

        // Reset mid-hold at lcnt=6, button held through reset
        k = cyc;
        btn_raw = 4'b0111;
        expect_at(k + 6,  4'b0111, 4'b1000, 4'b0000, 1'b0);
        expect_at(k + 11, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        step(12);
        rst_n = 1'b0;
        #1;
        chk("midhold_btn_db", btn_db, 4'b1111);
        chk("midhold_setup", {3'b000, setup_mode}, 4'b0000);
        chk("midhold_press", press_pulse, 4'b0000);
        step(2);
        rst_n = 1'b1;
        k = cyc;
        expect_at(k + 5,  4'b1111, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 6,  4'b0111, 4'b1000, 4'b0000, 1'b0);
        expect_at(k + 15, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        expect_at(k + 16, 4'b0111, 4'b0000, 4'b0000, LP_ON);
        step(20);
        btn_raw = 4'b1111;
        k = cyc;
        expect_at(k + 6, 4'b1111, 4'b0000, 4'b1000, LP_ON);
        step(10);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
